he_frame_ctrl: RTL
==================

Name: he_frame_ctrl

Overview:
- Frame-level sequencer for the histogram-equalization datapath (histogram RAM, CDF accumulator, LUT RAM, frame buffer).
- Orders the phases clear -> histogram -> CDF -> LUT build -> remap -> done, and generates bin sweeps and frame-buffer addresses.
- Provides valid/ready handshakes at the pixel input and the remapped-pixel output.
- Holds no pixel data; it drives the enables and addresses of the arithmetic blocks.

Parameters:
- IMAGE_WIDTH, 660, pixels per line
- IMAGE_HEIGHT, 440, lines per frame
- NUM_PIXELS, IMAGE_WIDTH*IMAGE_HEIGHT (290400), pixels per frame
- NUM_BINS, 256, histogram bins; must be a power of 2
- PIPE_LAT, 2, remap read latency in cycles (frame-buffer read, then LUT read)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- abort  in  1  return to IDLE at the next edge from any state
- in_valid  in  1  input pixel present
- in_ready  out  1  controller accepts the input pixel
- out_ready  in  1  downstream can take the output pixel
- out_valid  out  1  remapped pixel valid at the datapath output
- hist_clr  out  1  write zero to histogram[bin_addr]
- hist_inc  out  1  increment histogram[pixel]
- fb_we  out  1  write input pixel to frame buffer at fb_addr
- fb_re  out  1  read frame buffer at fb_addr
- fb_addr  out  19  frame-buffer address
- bin_addr  out  8  bin sweep address (log2 NUM_BINS)
- cdf_en  out  1  accumulate cdf += histogram[bin_addr]
- cdf_clr  out  1  zero the CDF accumulator
- lut_we  out  1  write LUT[bin_addr] = 255*cdf[bin_addr]/NUM_PIXELS
- pipe_en  out  1  advance the remap datapath registers
- busy  out  1  state != IDLE
- done  out  1  single-cycle pulse at the end of a frame
- state  out  3  current state, for debug

Behaviour:
- States: IDLE=0, CLEAR=1, HIST=2, CDF=3, LUT=4, REMAP=5, DONE=6.
- Reset:
  - state=IDLE; all outputs 0; counters 0; the valid shift register is cleared.
  - Reset in the middle of any phase gives the same result. Histogram contents are not cleared by reset; the CLEAR phase clears them.
- abort:
  - Has priority over every transition except reset.
  - Next state IDLE, counters zeroed, valid pipe flushed, done stays 0.
- IDLE:
  - start=1 -> CLEAR, bin_addr=0, cdf_clr pulses for one cycle.
  - Otherwise stay in IDLE.
- CLEAR:
  - hist_clr=1 every cycle, bin_addr increments 0..NUM_BINS-1.
  - Exactly NUM_BINS cycles, then -> HIST with fb_addr=0.
- HIST:
  - in_ready=1.
  - On each in_valid&in_ready cycle: hist_inc=1, fb_we=1 at the current fb_addr, then fb_addr increments.
  - No advance when in_valid=0.
  - The transfer where fb_addr==NUM_PIXELS-1 is the last one. On that cycle in_ready is still 1; the next state is CDF with in_ready=0 and bin_addr=0.
- CDF:
  - cdf_en=1 with bin_addr 0..NUM_BINS-1, one cycle each, NUM_BINS cycles.
  - The datapath stores cdf[bin_addr] after the add.
  - Then -> LUT with bin_addr=0.
- LUT:
  - lut_we=1 with bin_addr 0..NUM_BINS-1, NUM_BINS cycles.
  - Then -> REMAP with fb_addr=0.
- REMAP:
  - pipe_en=out_ready.
  - Issue stage: when out_ready=1 and the issue count is below NUM_PIXELS, assert fb_re at fb_addr, then fb_addr increments.
  - A PIPE_LAT-deep valid shift register advances only when pipe_en=1; its input is fb_re. out_valid is its last stage.
  - A transfer is out_valid&out_ready. When out_ready=0, all stages hold and no pixel is lost or duplicated.
  - Output count reaching NUM_PIXELS -> DONE. out_valid drops in the cycle after the last transfer.
- DONE:
  - done=1 for one cycle, then -> IDLE. busy=1 in DONE.
  - A start asserted in the DONE cycle is ignored.
- Counter widths:
  - fb_addr and the issue/output counters are 19 bits and never wrap; they stop at NUM_PIXELS.
  - bin_addr wraps to 0 naturally at the end of each sweep.
- Simultaneous events:
  - start in a non-IDLE state is ignored.
  - in_valid outside HIST is ignored, with in_ready=0.
  - abort together with start in IDLE: abort wins and the state stays IDLE.
- Cycle count with no stalls: 1 (IDLE->CLEAR) + 256 + NUM_PIXELS + 256 + 256 + NUM_PIXELS + PIPE_LAT + 1.

Test Plan:
- Nominal frame, IMAGE_WIDTH=4, IMAGE_HEIGHT=2 (8 pixels), in_valid and out_ready held high:
  - CLEAR lasts 256 cycles, HIST 8, CDF 256, LUT 256.
  - fb_re on fb_addr 0..7; out_valid high for 8 cycles starting 2 cycles after the first fb_re.
  - done pulses once, then busy=0.
- Input bubbles: in_valid pattern 1,0,1,0,... in HIST -> exactly 8 hist_inc/fb_we pulses with fb_addr 0..7, and HIST lasts 15 cycles.
- Output backpressure: out_ready=0 for 5 cycles mid-REMAP -> pipe_en=0, fb_addr frozen, out_valid held; exactly 8 transfers total with addresses in order.
- abort asserted on cycle 3 of CDF -> next state IDLE, all enables 0, no done pulse; a following start runs a full clean frame.
- reset asserted mid-REMAP with out_valid=1 -> next cycle out_valid=0, state=0, fb_addr=0.
- start asserted in HIST and in DONE -> ignored: no restart, and a single done pulse per frame.

Source files
------------

// File: rtl/he_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | he_frame_ctrl : phase sequencer for the histogram-equalization datapath    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module he_frame_ctrl #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440,
  parameter int NUM_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int NUM_BINS     = 256,
  parameter int PIPE_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic                        hist_clr,
  output logic                        hist_inc,
  output logic                        fb_we,
  output logic                        fb_re,
  output logic [18:0]                 fb_addr,
  output logic [$clog2(NUM_BINS)-1:0] bin_addr,
  output logic                        cdf_en,
  output logic                        cdf_clr,
  output logic                        lut_we,
  output logic                        pipe_en,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  state
);

  localparam int                BIN_W      = $clog2(NUM_BINS);
  localparam logic [BIN_W-1:0]  c_LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [18:0]       c_NPIX     = 19'(NUM_PIXELS);
  localparam logic [18:0]       c_LAST_PIX = 19'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HIST  = 3'd2,
    S_CDF   = 3'd3,
    S_LUT   = 3'd4,
    S_REMAP = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BIN_W-1:0]      r_bin;
  logic [18:0]           r_fb;
  logic [18:0]           r_ocnt;
  logic [PIPE_LAT-1:0]   r_vpipe;
  logic [PIPE_LAT-1:0]   w_vpipe_shift;
  logic                  r_cdf_clr;

  logic w_bin_last;
  logic w_in_xfer;
  logic w_pipe_en;
  logic w_issue;
  logic w_out_vld;
  logic w_out_xfer;

  assign w_bin_last = (r_bin == c_LAST_BIN);
  assign w_in_xfer  = (r_state == S_HIST) & in_valid;
  assign w_pipe_en  = (r_state == S_REMAP) & out_ready;
  assign w_issue    = w_pipe_en & (r_fb < c_NPIX);
  assign w_out_vld  = (r_state == S_REMAP) & r_vpipe[PIPE_LAT-1];
  assign w_out_xfer = w_out_vld & out_ready;

  // Valid tokens shadow the frame-buffer/LUT read pipeline one stage per advance.
  generate
    if (PIPE_LAT == 1) begin : g_pipe_single
      assign w_vpipe_shift = w_issue;
    end else begin : g_pipe_multi
      assign w_vpipe_shift = {r_vpipe[PIPE_LAT-2:0], w_issue};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    hist_clr    = 1'b0;
    hist_inc    = 1'b0;
    fb_we       = 1'b0;
    fb_re       = 1'b0;
    cdf_en      = 1'b0;
    lut_we      = 1'b0;
    pipe_en     = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        hist_clr = 1'b1;
        if (w_bin_last) w_state_nxt = S_HIST;
      end
      S_HIST: begin
        in_ready = 1'b1;
        hist_inc = w_in_xfer;
        fb_we    = w_in_xfer;
        if (w_in_xfer && (r_fb == c_LAST_PIX)) w_state_nxt = S_CDF;
      end
      S_CDF: begin
        cdf_en = 1'b1;
        if (w_bin_last) w_state_nxt = S_LUT;
      end
      S_LUT: begin
        lut_we = 1'b1;
        if (w_bin_last) w_state_nxt = S_REMAP;
      end
      S_REMAP: begin
        pipe_en = w_pipe_en;
        fb_re   = w_issue;
        if (w_out_xfer && (r_ocnt == c_LAST_PIX)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort) w_state_nxt = S_IDLE;
  end

  // Bin sweeps wrap naturally; pixel counters saturate at NUM_PIXELS.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_bin     <= '0;
      r_fb      <= '0;
      r_ocnt    <= '0;
      r_cdf_clr <= 1'b0;
    end else begin
      r_cdf_clr <= (r_state == S_IDLE) & start;
      case (r_state)
        S_CLEAR, S_CDF: begin
          r_bin <= r_bin + 1'b1;
        end
        S_LUT: begin
          r_bin <= r_bin + 1'b1;
          if (w_bin_last) r_fb <= '0;
        end
        S_HIST: begin
          if (w_in_xfer && (r_fb != c_NPIX)) r_fb <= r_fb + 19'd1;
        end
        S_REMAP: begin
          if (w_issue) r_fb <= r_fb + 19'd1;
          if (w_out_xfer && (r_ocnt != c_NPIX)) r_ocnt <= r_ocnt + 19'd1;
        end
        S_DONE: begin
          r_fb   <= '0;
          r_ocnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      r_vpipe <= '0;
    end else if (r_state != S_REMAP) begin
      r_vpipe <= '0;
    end else if (w_pipe_en) begin
      r_vpipe <= w_vpipe_shift;
    end
  end

  assign out_valid = w_out_vld;
  assign fb_addr   = r_fb;
  assign bin_addr  = r_bin;
  assign cdf_clr   = r_cdf_clr;
  assign state     = r_state;

endmodule
`default_nettype wire
